seg_scan_display: RTL and testbench

Parametrised multi-digit 7-segment display controller, successor to the two-digit OTP display path. It latches a value plus a display mode, and renders the value as decimal, hex or a status word. Decimal conversion is sequential (double-dabble), and the digits are driven by time-multiplexing one shared segment bus. It adds blink, overflow detection, leading-zero blanking and a busy handshake, and sits between the authentication FSM/OTP logic and the board display pins.

---
 rtl/seg_scan_display_if.sv | 26 ++
 rtl/seg_scan_display.sv | 255 +++++++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: request and display-pin bundle
// for the multiplexed 7-segment controller.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16
) ();
  logic                  load;
  logic [DATA_W-1:0]     value;
  logic [1:0]            mode;
  logic [1:0]            status;
  logic                  blink;
  logic                  busy;
  logic                  ovf;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (
    output load, value, mode, status, blink,
    input  busy, ovf, seg, an
  );

  modport slave (
    input  load, value, mode, status, blink,
    output busy, ovf, seg, an
  );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: decimal/hex/status renderer with
// double-dabble conversion, digit scan and blink.
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic clk,
  input  logic rst,
  seg_scan_display_if.slave io
);

  localparam int BCD_D = (DATA_W * 3) / 10 + 2;
  localparam int BCD_W = BCD_D * 4;
  localparam int PAD_W = (4 * NUM_DIGITS > DATA_W)
                       ? 4 * NUM_DIGITS : DATA_W;
  localparam int IW = (NUM_DIGITS > 1)
                    ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_C     = 7'h46;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_LO    = 7'h23;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_N     = 7'h2B;
  localparam logic [6:0] G_R     = 7'h2F;
  localparam logic [6:0] G_H     = 7'h09;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [6:0] glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [6:0]        buf_q  [NUM_DIGITS];
  logic [6:0]        wr_buf [NUM_DIGITS];
  logic              wr_en, wr_ovf, ovf_q;
  logic [RW-1:0]     rcnt_q;
  logic [IW-1:0]     idx_q;
  logic [BW-1:0]     bcnt_q;
  logic              phase_off_q;
  logic [6:0]        seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic              accept, last;

  assign accept = io.load && (state_q == IDLE);
  assign last   = (state_q == CONV)
               && (cnt_q == CW'(DATA_W - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one CONV cycle per input bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && io.mode == 2'b00)
              state_d = CONV;
      CONV: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // one double-dabble step: add-3 then shift in next bit
  always_comb begin : dabble
    logic [BCD_W-1:0] adj;
    logic [3:0]       d;
    adj = '0;
    d   = '0;
    for (int j = 0; j < BCD_D; j++) begin
      d = bcd_q[4*j +: 4];
      adj[4*j +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    bcd_d = BCD_W'({adj, bin_q[DATA_W-1]});
  end

  // conversion datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      bin_q <= io.value;
      bcd_q <= '0;
    end else if (state_q == CONV) begin
      cnt_q <= cnt_q + 1'b1;
      bin_q <= bin_q << 1;
      bcd_q <= bcd_d;
    end
  end

  // build the next buffer image for any update source
  always_comb begin : render
    logic [PAD_W-1:0] pad;
    logic [6:0]       txt [4];
    logic             nz;
    logic [3:0]       d;
    wr_en  = 1'b0;
    wr_ovf = 1'b0;
    pad    = PAD_W'(io.value);
    nz     = 1'b0;
    d      = '0;
    for (int i = 0; i < 4; i++) txt[i] = G_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++)
      wr_buf[i] = G_BLANK;
    if (last) begin
      wr_en = 1'b1;
      for (int j = NUM_DIGITS; j < BCD_D; j++)
        if (bcd_d[4*j +: 4] != 4'd0) wr_ovf = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        d = 4'd0;
        if (i < BCD_D) d = bcd_d[(4*i) % BCD_W +: 4];
        nz = nz || (d != 4'd0);
        wr_buf[i] = (nz || i == 0) ? glyph(d) : G_BLANK;
      end
      if (wr_ovf)
        for (int i = 0; i < NUM_DIGITS; i++)
          wr_buf[i] = G_DASH;
    end else if (accept) begin
      unique case (io.mode)
        2'b00: wr_en = 1'b0;
        2'b01: begin
          wr_en  = 1'b1;
          wr_ovf = |(pad >> (4 * NUM_DIGITS));
          for (int i = 0; i < NUM_DIGITS; i++)
            wr_buf[i] = glyph(pad[4*i +: 4]);
        end
        2'b10: begin
          wr_en = 1'b1;
          unique case (io.status)
            2'b00: begin
              txt[2] = G_L;
              txt[1] = G_LO;
              txt[0] = G_C;
            end
            2'b01: begin
              txt[3] = G_O;
              txt[2] = G_P;
              txt[1] = G_E;
              txt[0] = G_N;
            end
            2'b10: begin
              txt[2] = G_E;
              txt[1] = G_H;
              txt[0] = G_P;
            end
            2'b11: begin
              txt[3] = G_E;
              txt[2] = G_R;
              txt[1] = G_R;
              txt[0] = glyph({2'b00, io.value[1:0]});
            end
          endcase
          for (int i = 0; i < NUM_DIGITS; i++)
            if (i < 4) wr_buf[i] = txt[i % 4];
        end
        2'b11: wr_en = 1'b1;
      endcase
    end
  end

  // display buffer and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        buf_q[i] <= G_BLANK;
      ovf_q <= 1'b0;
    end else if (wr_en) begin
      buf_q <= wr_buf;
      ovf_q <= wr_ovf;
    end
  end

  // refresh divider and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_q <= '0;
      idx_q  <= (idx_q == IW'(NUM_DIGITS - 1))
              ? '0 : idx_q + 1'b1;
    end else begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  // free-running blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q      <= '0;
      phase_off_q <= 1'b0;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_q      <= '0;
      phase_off_q <= ~phase_off_q;
    end else begin
      bcnt_q <= bcnt_q + 1'b1;
    end
  end

  // registered pin drive, seg and an aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= G_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= buf_q[idx_q];
      an_q  <= (io.blink && phase_off_q) ? '1
             : ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  assign io.busy = (state_q == CONV);
  assign io.ovf  = ovf_q;
  assign io.seg  = seg_q;
  assign io.an   = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan,
// decimal/hex/status rendering, blink and reset.
module tb_seg_scan_display;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [6:0] dig [ND];

  always #5 clk = ~clk;

  seg_scan_display_if #(.NUM_DIGITS(ND), .DATA_W(DW)) io ();

  seg_scan_display #(
    .NUM_DIGITS(ND), .DATA_W(DW),
    .REFRESH_DIV(RD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  task automatic grab();
    for (int k = 0; k < ND; k++) dig[k] = 7'h55;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++)
        if (io.an == ~(ND'(1) << k)) dig[k] = io.seg;
    end
  endtask

  task automatic load_val(input logic [1:0] m,
                          input logic [1:0] s,
                          input logic [DW-1:0] v);
    @(negedge clk);
    io.load = 1'b1;
    io.mode = m;
    io.status = s;
    io.value = v;
    @(negedge clk);
    io.load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (io.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [ND-1:0] e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (io.seg !== 7'h7F) begin fails++;
      $display("FAIL rst_seg got %h want 7f", io.seg); end
    tests++;
    if (io.an !== 4'hF) begin fails++;
      $display("FAIL rst_an got %b want 1111", io.an); end
    tests++;
    if (io.busy !== 1'b0 || io.ovf !== 1'b0) begin fails++;
      $display("FAIL rst_flags busy %b ovf %b want 0 0",
               io.busy, io.ovf); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = ~(ND'(1) << (k / 4));
      tests++;
      if (io.an !== e || io.seg !== 7'h7F) begin fails++;
        $display("FAIL scan_walk cyc %0d an %b seg %h want %b 7f",
                 k, io.an, io.seg, e); end
    end
  endtask

  task automatic test_dec_1234();
    logic [6:0] e [ND];
    int n;
    e = '{7'h19, 7'h30, 7'h24, 7'h79};
    load_val(2'b00, 2'b00, 16'd1234);
    n = 0;
    while (io.busy && n < 40) begin
      if (n == 3) begin io.load = 1'b1; io.value = 16'd9; end
      if (n == 4) io.load = 1'b0;
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 16) begin fails++;
      $display("FAIL busy_len got %0d want 16", n); end
    repeat (2) @(negedge clk);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL dec1234 d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
    tests++;
    if (io.ovf !== 1'b0) begin fails++;
      $display("FAIL dec1234_ovf got %b want 0", io.ovf); end
  endtask

  task automatic test_dec_42();
    logic [6:0] e [ND];
    int n;
    e = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    load_val(2'b00, 2'b00, 16'd42);
    wait_idle(n);
    tests++;
    if (n !== 16) begin fails++;
      $display("FAIL dec42_busy got %0d want 16", n); end
    repeat (2) @(negedge clk);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL dec42 d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
  endtask

  task automatic test_dec_ovf();
    int n;
    load_val(2'b00, 2'b00, 16'd12345);
    wait_idle(n);
    repeat (2) @(negedge clk);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== 7'h3F) begin fails++;
        $display("FAIL dec_ovf d%0d got %h want 3f",
                 k, dig[k]); end
    end
    tests++;
    if (io.ovf !== 1'b1) begin fails++;
      $display("FAIL dec_ovf_flag got %b want 1", io.ovf); end
  endtask

  task automatic test_dec_zero();
    logic [6:0] e [ND];
    int n;
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    load_val(2'b00, 2'b00, 16'd0);
    wait_idle(n);
    repeat (2) @(negedge clk);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL dec0 d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
    tests++;
    if (io.ovf !== 1'b0) begin fails++;
      $display("FAIL dec0_ovf got %b want 0", io.ovf); end
  endtask

  task automatic test_hex();
    logic [6:0] e [ND];
    e = '{7'h0E, 7'h06, 7'h06, 7'h03};
    load_val(2'b01, 2'b00, 16'hBEEF);
    tests++;
    if (io.busy !== 1'b0) begin fails++;
      $display("FAIL hex_busy got %b want 0", io.busy); end
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL hex d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
  endtask

  task automatic test_status();
    logic [6:0] e [ND];
    e = '{7'h24, 7'h2F, 7'h2F, 7'h06};
    load_val(2'b10, 2'b11, 16'h0002);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL err2 d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
    e = '{7'h46, 7'h23, 7'h47, 7'h7F};
    load_val(2'b10, 2'b00, 16'h0000);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== e[k]) begin fails++;
        $display("FAIL loc d%0d got %h want %h",
                 k, dig[k], e[k]); end
    end
    load_val(2'b11, 2'b00, 16'h1234);
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== 7'h7F) begin fails++;
        $display("FAIL mode3 d%0d got %h want 7f",
                 k, dig[k]); end
    end
  endtask

  task automatic test_blink();
    int n;
    int bad;
    io.blink = 1'b1;
    n = 0;
    while (io.an !== 4'hF && n < 20) begin
      n++; @(negedge clk);
    end
    n = 0;
    while (io.an === 4'hF && n < 20) begin
      n++; @(negedge clk);
    end
    n = 0;
    while (io.an !== 4'hF && n < 30) begin
      n++; @(negedge clk);
    end
    tests++;
    if (n !== 8) begin fails++;
      $display("FAIL blink_on got %0d want 8", n); end
    n = 0;
    while (io.an === 4'hF && n < 30) begin
      n++; @(negedge clk);
    end
    tests++;
    if (n !== 8) begin fails++;
      $display("FAIL blink_off got %0d want 8", n); end
    io.blink = 1'b0;
    @(negedge clk);
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (io.an === 4'hF) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++;
      $display("FAIL noblink got %0d dark want 0", bad); end
  endtask

  task automatic test_reset_mid();
    load_val(2'b00, 2'b00, 16'd9999);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (io.busy !== 1'b0 || io.seg !== 7'h7F || io.an !== 4'hF)
    begin fails++;
      $display("FAIL rst_mid busy %b seg %h an %b want 0 7f 1111",
               io.busy, io.seg, io.an); end
    rst = 1'b0;
    grab();
    for (int k = 0; k < ND; k++) begin
      tests++;
      if (dig[k] !== 7'h7F) begin fails++;
        $display("FAIL rst_mid_blank d%0d got %h want 7f",
                 k, dig[k]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    io.load = 1'b0;
    io.value = '0;
    io.mode = 2'b00;
    io.status = 2'b00;
    io.blink = 1'b0;
    test_reset();
    test_dec_1234();
    test_dec_42();
    test_dec_ovf();
    test_dec_zero();
    test_hex();
    test_status();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
